uart_rx_fifo: RTL and testbench

//  Parametrised UART receive path for UARTTOP: oversampling baud-tick generator, 2-flop rx synchroniser,

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_sync_fifo.sv | 57 +++++
 rtl/uart_rx_fifo.sv | 208 ++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path.
//   rx_state_t : frame FSM states
//   OVERSAMPLE : oversample ticks per bit
//   MID_TICK   : tick index of the start-bit midpoint
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/uart_sync_fifo.sv
// First-word-fall-through synchronous FIFO, reusable by the UART TX and RX paths.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset (pointers/count only)
//   wr, wdata : push request and data; accepted when not full, or when full with a pop
//   rd        : pop request; ignored while empty
//   rdata     : head entry, zero while empty
//   full      : count == 2**AW
//   empty     : count == 0
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             rd,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count;
  logic             wr_en, rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // When full, a simultaneous pop frees the slot the push lands in (wptr == rptr).
  assign wr_en = wr && (!full || rd);
  assign rd_en = rd && !empty;
  assign rdata = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_en) wptr <= wptr + AW'(1);
      if (rd_en) rptr <= rptr + AW'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive path: oversampling tick generator, 2-flop rx synchroniser, frame FSM
// and a FWFT receive FIFO (uart_sync_fifo).
// Build option: define UART_RX_PARITY_EN to receive one parity bit after the data bits
// (even/odd per PARITY_ODD) and drive parity_err; otherwise parity_err is tied 0.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : serial input, idle high, asynchronous to clk
//   rduart     : pop request (one entry per cycle while high and not empty)
//   rdata      : FIFO head, zero while empty
//   rxempty    : FIFO empty
//   rxfull     : FIFO full
//   frame_err  : 1-clk pulse, stop bit sampled low
//   parity_err : 1-clk pulse, parity mismatch
//   overrun    : 1-clk pulse, good frame lost because FIFO full with no pop
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DVSR       = 651,
  parameter int DBIT       = 8,
  parameter int SB_TICK    = 16,
  parameter int FIFO_AW    = 2,
  parameter int PARITY_ODD = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rx,
  input  logic            rduart,
  output logic [DBIT-1:0] rdata,
  output logic            rxempty,
  output logic            rxfull,
  output logic            frame_err,
  output logic            parity_err,
  output logic            overrun
);

  // Nonzero when data, received parity bit and the odd/even selection disagree.
  function automatic logic parity_bad(input logic [DBIT-1:0] d, input logic p);
    return ^{d, p, (PARITY_ODD != 0)};
  endfunction

  logic [15:0]     tick_cnt;
  logic            s_tick;
  logic            rx_p0, rx_p1;
  rx_state_t       state_q, state_d;
  logic [4:0]      n_q, n_d;
  logic [3:0]      i_q, i_d;
  logic [DBIT-1:0] shreg_q, shreg_d;
  logic            push, ferr_d, ovr_d;
`ifdef UART_RX_PARITY_EN
  logic            par_q, par_d, perr_d;
`endif

  // ---- tick generator: free-running, one-clk strobe every DVSR cycles
  assign s_tick = (tick_cnt == 16'(DVSR - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         tick_cnt <= '0;
    else if (s_tick) tick_cnt <= '0;
    else             tick_cnt <= tick_cnt + 16'd1;
  end

  // ---- stage p0/p1: rx synchroniser, resets to the idle level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_p0 <= 1'b1;
      rx_p1 <= 1'b1;
    end else begin
      rx_p0 <= rx;
      rx_p1 <= rx_p0;
    end
  end

  // ---- frame FSM on synchronised rx (rx_p1), advancing only on s_tick
  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    i_d     = i_q;
    shreg_d = shreg_q;
    push    = 1'b0;
    ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    if (s_tick) begin
      case (state_q)
        IDLE: begin
          if (!rx_p1) begin
            state_d = START;
            n_d     = '0;
          end
        end
        START: begin
          if (n_q == 5'(MID_TICK)) begin
            if (!rx_p1) begin
              state_d = DATA;
              n_d     = '0;
              i_d     = '0;
            end else begin
              state_d = IDLE;  // false start: line back high at mid start bit
            end
          end else begin
            n_d = n_q + 5'd1;
          end
        end
        DATA: begin
          if (n_q == 5'(OVERSAMPLE - 1)) begin
            n_d     = '0;
            shreg_d = {rx_p1, shreg_q[DBIT-1:1]};  // LSB first, right-justified after DBIT shifts
            if (i_q == 4'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
              state_d = PARITY;
`else
              state_d = STOP;
`endif
            end else begin
              i_d = i_q + 4'd1;
            end
          end else begin
            n_d = n_q + 5'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (n_q == 5'(OVERSAMPLE - 1)) begin
            par_d   = rx_p1;
            n_d     = '0;
            state_d = STOP;
          end else begin
            n_d = n_q + 5'd1;
          end
        end
`endif
        STOP: begin
          if (n_q == 5'(SB_TICK - 1)) begin
            state_d = IDLE;
            n_d     = '0;
            if (!rx_p1) ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            else if (parity_bad(shreg_q, par_q)) perr_d = 1'b1;
`endif
            else push = 1'b1;
          end else begin
            n_d = n_q + 5'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A pop in the same cycle makes room, so only a push into a full FIFO without pop is lost.
  assign ovr_d = push && rxfull && !rduart;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      i_q     <= i_d;
    end
  end

  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
`ifdef UART_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  // ---- stage p2: registered error pulses, one clk after the stop sample
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr_d;
      overrun   <= ovr_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) parity_err <= 1'b0;
    else     parity_err <= perr_d;
  end
`else
  assign parity_err = 1'b0;
`endif

  uart_sync_fifo #(
    .WIDTH (DBIT),
    .AW    (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .wr    (push),
    .wdata (shreg_q),
    .rd    (rduart),
    .rdata (rdata),
    .full  (rxfull),
    .empty (rxempty)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected bytes / error pulses
// into queues; a negedge monitor pops and compares whenever the DUT pops data or pulses.
module tb_uart_rx_fifo;

  localparam int DVSR       = 2;
  localparam int DBIT       = 8;
  localparam int SB_TICK    = 16;
  localparam int FIFO_AW    = 2;
  localparam int PARITY_ODD = 0;
  localparam int BIT_CLK    = 16 * DVSR;
`ifdef UART_RX_PARITY_EN
  localparam int NPAR = 1;
`else
  localparam int NPAR = 0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            rx;
  logic            rduart;
  logic [DBIT-1:0] rdata;
  logic            rxempty, rxfull, frame_err, parity_err, overrun;

  uart_rx_fifo #(
    .DVSR(DVSR), .DBIT(DBIT), .SB_TICK(SB_TICK), .FIFO_AW(FIFO_AW), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .clk(clk), .rst(rst), .rx(rx), .rduart(rduart), .rdata(rdata),
    .rxempty(rxempty), .rxfull(rxfull), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  logic [DBIT-1:0] exp_q[$];
  logic [2:0]      pulse_q[$];   // {overrun, parity_err, frame_err}
  int              fall_cyc = -1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---- monitor / scoreboard
  logic [2:0] prev_vec = 3'b000;
  logic       prev_empty = 1'b1;
  always @(negedge clk) begin
    logic [2:0] vec;
    logic [2:0] ev;
    vec = {overrun, parity_err, frame_err};
    if (!rst) begin
      if (rduart && !rxempty) begin
        if (exp_q.size() == 0) check("unexpected_pop", 32'(rdata), 32'hxx);
        else                   check("pop_data", 32'(rdata), 32'(exp_q.pop_front()));
      end
      if (vec != 3'b000) begin
        ev = (pulse_q.size() != 0) ? pulse_q.pop_front() : 3'b000;
        check("pulse_kind", 32'(vec), 32'(ev));
        check("pulse_width", 32'(vec & prev_vec), 32'h0);
      end
      if (prev_empty && !rxempty) fall_cyc = cyc;
    end
    prev_vec   = vec;
    prev_empty = rxempty;
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Start every frame on an even cycle so the tick phase matches the calibration frame.
  task automatic align();
    @(posedge clk); #1;
    if (cyc[0]) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input logic [DBIT-1:0] d, input bit bad_stop, input bit flip_par);
    rx = 1'b0;
    clk_n(BIT_CLK);
    for (int b = 0; b < DBIT; b++) begin
      rx = d[b];
      clk_n(BIT_CLK);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ (PARITY_ODD != 0) ^ flip_par;
    clk_n(BIT_CLK);
`endif
    if (bad_stop) begin
      rx = 1'b0;
      clk_n(24);
      rx = 1'b1;
      clk_n(BIT_CLK - 24);
    end else begin
      rx = 1'b1;
      clk_n(SB_TICK * DVSR);
    end
    rx = 1'b1;
    clk_n(2 * BIT_CLK);
  endtask

  task automatic pop_n(input int n);
    rduart = 1'b1;
    clk_n(n);
    rduart = 1'b0;
  endtask

  int s, lat;

  initial begin
    rst = 1'b1; rx = 1'b1; rduart = 1'b0;
    clk_n(3);
    check("rst_rxempty", 32'(rxempty), 32'h1);
    check("rst_rxfull", 32'(rxfull), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);
    rst = 1'b0;
    clk_n(4);

    // 1: reset in the middle of a frame
    align();
    rx = 1'b0; clk_n(BIT_CLK);
    rx = 1'b1; clk_n(BIT_CLK);
    rx = 1'b0; clk_n(16);
    rst = 1'b1; rx = 1'b1;
    for (int k = 0; k < 3; k++) begin
      clk_n(1);
      check("midrst_rxempty", 32'(rxempty), 32'h1);
      check("midrst_rxfull", 32'(rxfull), 32'h0);
      check("midrst_rdata", 32'(rdata), 32'h0);
      check("midrst_pulses", 32'({overrun, parity_err, frame_err}), 32'h0);
    end
    rst = 1'b0;
    clk_n(2 * BIT_CLK);
    check("after_rst_empty", 32'(rxempty), 32'h1);
    exp_q.push_back(8'hA5);
    align();
    send_frame(8'hA5, 1'b0, 1'b0);
    check("a5_rdata", 32'(rdata), 32'hA5);
    pop_n(1);
    check("a5_empty_after_pop", 32'(rxempty), 32'h1);

    // 2: single frame, push latency calibration
    exp_q.push_back(8'h5A);
    align();
    s = cyc;
    send_frame(8'h5A, 1'b0, 1'b0);
    lat = fall_cyc - s;
    check("push_latency_in_window",
          32'((lat >= 300 + 32*NPAR) && (lat <= 316 + 32*NPAR)), 32'h1);
    if (!((lat >= 300 + 32*NPAR) && (lat <= 316 + 32*NPAR))) lat = 307 + 32*NPAR;
    check("5a_rxempty", 32'(rxempty), 32'h0);
    check("5a_rdata", 32'(rdata), 32'h5A);
    pop_n(1);
    check("5a_empty_after_pop", 32'(rxempty), 32'h1);
    check("5a_rdata_zero", 32'(rdata), 32'h0);

    // 3: overrun on the fifth frame
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(DBIT'(k));
      else        pulse_q.push_back(3'b100);
      align();
      send_frame(DBIT'(k), 1'b0, 1'b0);
      if (k == 3) check("full_after_3", 32'(rxfull), 32'h0);
      if (k == 4) check("full_after_4", 32'(rxfull), 32'h1);
    end
    check("full_after_5", 32'(rxfull), 32'h1);
    pop_n(4);
    check("drained_empty", 32'(rxempty), 32'h1);
    pop_n(2);
    check("pop_on_empty_rdata", 32'(rdata), 32'h0);
    check("pop_on_empty_rxempty", 32'(rxempty), 32'h1);

    // 4: framing error, then a short low glitch on the idle line
    pulse_q.push_back(3'b001);
    align();
    send_frame(8'h33, 1'b1, 1'b0);
    check("ferr_fifo_unchanged", 32'(rxempty), 32'h1);
    align();
    rx = 1'b0; clk_n(12);
    rx = 1'b1; clk_n(4 * BIT_CLK);
    check("glitch_no_frame", 32'(rxempty), 32'h1);
    check("ferr_seen", 32'(pulse_q.size()), 32'h0);

`ifdef UART_RX_PARITY_EN
    // 5: parity accepted / rejected
    exp_q.push_back(8'h07);
    align();
    send_frame(8'h07, 1'b0, 1'b0);
    pulse_q.push_back(3'b010);
    align();
    send_frame(8'h07, 1'b0, 1'b1);
    check("par_rdata", 32'(rdata), 32'h07);
    pop_n(1);
    check("par_bad_not_pushed", 32'(rxempty), 32'h1);
`endif

    // 6: full FIFO with a pop in the push cycle of the fifth frame
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(DBIT'(k));
      align();
      send_frame(DBIT'(k), 1'b0, 1'b0);
    end
    check("t6_full", 32'(rxfull), 32'h1);
    exp_q.push_back(8'h05);
    align();
    fork
      send_frame(8'h05, 1'b0, 1'b0);
      begin
        repeat (lat - 1) @(posedge clk);
        #1 rduart = 1'b1;
        @(posedge clk);
        #1 rduart = 1'b0;
      end
    join
    check("t6_still_full", 32'(rxfull), 32'h1);
    pop_n(4);
    check("t6_empty", 32'(rxempty), 32'h1);

    clk_n(10);
    check("exp_q_drained", 32'(exp_q.size()), 32'h0);
    check("pulse_q_drained", 32'(pulse_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
